// File: rtl/tb_wait_state_memory_if.sv
// Request/response bus of the wait-state bench memory.
// The requester drives the master side and the memory model sits on the slave side.
interface tb_wait_state_memory_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_sz;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_sz, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_sz, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/tb_wait_state_memory.sv
// Big-endian bench memory with per-direction wait states and a one-cycle registered response.
// Contents are not cleared by reset; the surrounding bench owns initial contents.
module tb_wait_state_memory #(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 1
) (
  input  logic                   write_clk,
  input  logic                   reset,
  tb_wait_state_memory_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t                state_r, state_s;
  logic [3:0]            cnt_r;
  logic                  we_r;
  logic [1:0]            sz_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic                  resp_valid_r;
  logic                  resp_err_r;
  logic [31:0]           resp_rdata_r;
  logic                  ready_s;
  logic                  accept_s;
  logic                  complete_s;
  logic [31:0]           rdata_s;
  logic [ADDR_WIDTH-1:0] a0_s, a1_s, a2_s, a3_s;

  logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

  // Byte lanes wrap naturally modulo the address width
  assign a0_s = addr_r;
  assign a1_s = addr_r + ADDR_WIDTH'(1);
  assign a2_s = addr_r + ADDR_WIDTH'(2);
  assign a3_s = addr_r + ADDR_WIDTH'(3);

  assign bus.req_ready  = ready_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_rdata_r;

  // Handshake, completion detect and next-state selection
  always_comb begin
    ready_s    = 1'b0;
    state_s    = state_r;
    if (reset) begin
      ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    ready_s = 1'b1;
        BUSY:    ready_s = 1'b0;
        RESP:    ready_s = 1'b1;
        default: ready_s = 1'b0;
      endcase
    end
    accept_s   = bus.req_valid && ready_s;
    complete_s = (state_r == BUSY) && (cnt_r == 4'd0) && !reset;
    case (state_r)
      IDLE:    state_s = accept_s ? BUSY : IDLE;
      BUSY:    state_s = (cnt_r == 4'd0) ? RESP : BUSY;
      RESP:    state_s = accept_s ? BUSY : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Right-justified, zero-extended read data of the latched access
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (sz_r)
      2'd0:    rdata_s = {24'h00_0000, mem[a0_s]};
      2'd1:    rdata_s = {16'h0000, mem[a0_s], mem[a1_s]};
      2'd2:    rdata_s = {mem[a0_s], mem[a1_s], mem[a2_s], mem[a3_s]};
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  // State, request latch, wait counter and response registers
  always_ff @(posedge write_clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      resp_valid_r <= (state_s == RESP);
      if (accept_s) begin
        we_r    <= bus.req_we;
        sz_r    <= bus.req_sz;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
        cnt_r   <= bus.req_we ? 4'(WR_WAIT) : 4'(RD_WAIT);
      end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (complete_s) begin
        resp_err_r   <= (sz_r == 2'd3);
        resp_rdata_r <= (we_r || (sz_r == 2'd3)) ? 32'h0000_0000 : rdata_s;
      end
    end
  end

  // Commit a legal write at its completion edge
  always_ff @(posedge write_clk) begin
    if (complete_s && we_r) begin
      case (sz_r)
        2'd0: mem[a0_s] <= wdata_r[7:0];
        2'd1: begin
          mem[a0_s] <= wdata_r[15:8];
          mem[a1_s] <= wdata_r[7:0];
        end
        2'd2: begin
          mem[a0_s] <= wdata_r[31:24];
          mem[a1_s] <= wdata_r[23:16];
          mem[a2_s] <= wdata_r[15:8];
          mem[a3_s] <= wdata_r[7:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tb_wait_state_memory.sv
// Directed bench for tb_wait_state_memory: latency, endianness, wrap, illegal size,
// reset during an access and request hold-off.
module tb_tb_wait_state_memory;
  localparam int AW  = 16;
  localparam int RDW = 2;
  localparam int WRW = 4;

  logic write_clk = 1'b0;
  logic reset     = 1'b1;
  int   n_tests   = 0;
  int   n_fail    = 0;

  tb_wait_state_memory_if #(.ADDR_WIDTH(AW)) bus ();

  tb_wait_state_memory #(.ADDR_WIDTH(AW), .RD_WAIT(RDW), .WR_WAIT(WRW)) u_dut (
    .write_clk (write_clk),
    .reset     (reset),
    .bus       (bus.slave)
  );

  always #5 write_clk = ~write_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge
  task automatic issue(input logic we, input logic [1:0] sz, input logic [15:0] addr,
                       input logic [31:0] wdata);
    int guard = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_sz    = sz;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && guard < 20) begin
      @(negedge write_clk);
      guard++;
    end
    check_eq("accept_ready", 32'(bus.req_ready), 32'd1);
    @(posedge write_clk);
  endtask

  // Returns at the negedge of the response cycle
  task automatic wait_resp(input string tag, input int w, input logic [31:0] exp_rdata,
                           input logic exp_err, input bit hold);
    int n       = 0;
    bit seen    = 1'b0;
    bit busy_ok = 1'b1;
    while (n < 40 && !seen) begin
      @(negedge write_clk);
      n++;
      if (n == 1 && !hold) bus.req_valid = 1'b0;
      if (n == 1 && hold) begin
        bus.req_addr  = bus.req_addr ^ 16'h0001;
        bus.req_wdata = ~bus.req_wdata;
      end
      if (bus.resp_valid) seen = 1'b1;
      else if (bus.req_ready) busy_ok = 1'b0;
    end
    bus.req_valid = 1'b0;
    check_eq({tag, "_seen"},  32'(seen), 32'd1);
    check_eq({tag, "_lat"},   32'(n), 32'(w + 2));
    check_eq({tag, "_busy"},  32'(busy_ok), 32'd1);
    check_eq({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    check_eq({tag, "_err"},   32'(bus.resp_err), 32'(exp_err));
  endtask

  initial begin
    int pulses;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_sz    = 2'd0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 32'h0000_0000;
    for (int i = 0; i < (2**AW); i++) u_dut.mem[i] = 8'h00;
    u_dut.mem[16'h0010] = 8'h11;
    u_dut.mem[16'h0011] = 8'h22;
    u_dut.mem[16'h0012] = 8'h33;
    u_dut.mem[16'h0013] = 8'h44;
    u_dut.mem[16'h0020] = 8'h05;

    repeat (3) @(negedge write_clk);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_err",   32'(bus.resp_err), 32'd0);
    check_eq("rst_rdata", bus.resp_rdata, 32'h0);
    reset = 1'b0;
    @(negedge write_clk);
    check_eq("idle_ready", 32'(bus.req_ready), 32'd1);

    // 32-bit read latency and byte order
    issue(1'b0, 2'd2, 16'h0010, 32'h0);
    wait_resp("rd32", RDW, 32'h1122_3344, 1'b0, 1'b0);

    // 16-bit write, read accepted in the write's RESP cycle
    issue(1'b1, 2'd1, 16'h0100, 32'hDEAD_BEEF);
    wait_resp("wr16", WRW, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 2'd1, 16'h0100, 32'h0);
    wait_resp("rd16", RDW, 32'h0000_BEEF, 1'b0, 1'b0);
    check_eq("mem_0100", 32'(u_dut.mem[16'h0100]), 32'h0000_00BE);
    check_eq("mem_0101", 32'(u_dut.mem[16'h0101]), 32'h0000_00EF);

    // Address wrap across the top of memory
    @(negedge write_clk);
    issue(1'b1, 2'd2, 16'hFFFE, 32'hA1B2_C3D4);
    wait_resp("wrwrap", WRW, 32'h0, 1'b0, 1'b0);
    check_eq("mem_fffe", 32'(u_dut.mem[16'hFFFE]), 32'h0000_00A1);
    check_eq("mem_ffff", 32'(u_dut.mem[16'hFFFF]), 32'h0000_00B2);
    check_eq("mem_0000", 32'(u_dut.mem[16'h0000]), 32'h0000_00C3);
    check_eq("mem_0001", 32'(u_dut.mem[16'h0001]), 32'h0000_00D4);
    issue(1'b0, 2'd2, 16'hFFFE, 32'h0);
    wait_resp("rdwrap", RDW, 32'hA1B2_C3D4, 1'b0, 1'b0);

    // Illegal size, read then write, then a legal 8-bit read
    issue(1'b0, 2'd3, 16'h0020, 32'h0);
    wait_resp("rdill", RDW, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 2'd3, 16'h0020, 32'hFFFF_FFFF);
    wait_resp("wrill", WRW, 32'h0, 1'b1, 1'b0);
    check_eq("mem_0020", 32'(u_dut.mem[16'h0020]), 32'h0000_0005);
    issue(1'b0, 2'd0, 16'h0020, 32'h0);
    wait_resp("rd8", RDW, 32'h0000_0005, 1'b0, 1'b0);

    // Reset two edges after a write is accepted drops the write
    @(negedge write_clk);
    issue(1'b1, 2'd0, 16'h0040, 32'h0000_005A);
    @(negedge write_clk);
    bus.req_valid = 1'b0;
    @(negedge write_clk);
    reset = 1'b1;
    #1;
    check_eq("rstw_ready", 32'(bus.req_ready), 32'd0);
    @(negedge write_clk);
    reset = 1'b0;
    #1;
    check_eq("rstw_idle_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rstw_state", 32'(u_dut.state_r), 32'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge write_clk);
      if (bus.resp_valid) pulses++;
    end
    check_eq("rstw_no_resp", 32'(pulses), 32'd0);
    check_eq("mem_0040", 32'(u_dut.mem[16'h0040]), 32'h0);

    // Request inputs change while busy; only latched values count
    issue(1'b1, 2'd0, 16'h0200, 32'h0000_0077);
    wait_resp("hold_wr", WRW, 32'h0, 1'b0, 1'b1);
    check_eq("mem_0200", 32'(u_dut.mem[16'h0200]), 32'h0000_0077);
    check_eq("mem_0201", 32'(u_dut.mem[16'h0201]), 32'h0);
    @(negedge write_clk);
    issue(1'b0, 2'd2, 16'h0010, 32'h0);
    wait_resp("hold_rd", RDW, 32'h1122_3344, 1'b0, 1'b1);

    // Reset asserted in the response cycle
    reset = 1'b1;
    @(negedge write_clk);
    check_eq("rstr_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rstr_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge write_clk);
    check_eq("rstr_idle", 32'(bus.req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
